// File: rtl/io_bank_ice40.sv
// iCE40 IO bank: per-pin run-time function select with high-Z dead time on every change.
// Define IO_BANK_ICE40_OPENDRAIN_EN to make transmit functions drive open-drain.
module io_bank_ice40 #(
  parameter int unsigned PINCOUNT    = 4,
  parameter int unsigned RXCOUNT     = 2,
  parameter int unsigned TXCOUNT     = 2,
  parameter int unsigned DEADTIME    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned FUNCCOUNT  = RXCOUNT + TXCOUNT,
  localparam int unsigned MUXWIDTH   = $clog2(FUNCCOUNT + 1),
  localparam int unsigned ADDRWIDTH  = (PINCOUNT > 1) ? $clog2(PINCOUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  inout  wire  [PINCOUNT-1:0]           pin,
  input  logic [ADDRWIDTH-1:0]          cfg_addr,
  input  logic [MUXWIDTH-1:0]           cfg_sel,
  input  logic                          cfg_we,
  output logic [MUXWIDTH-1:0]           cfg_rdata,
  output logic [PINCOUNT-1:0]           pin_busy,
  output logic [PINCOUNT*RXCOUNT-1:0]   func_receive,
  input  logic [PINCOUNT*TXCOUNT-1:0]   func_transmit
);

  localparam int unsigned CntWidth = $clog2(DEADTIME + 1);

  typedef enum logic {StActive, StDrain} state_e;

  state_e                                 state_q [PINCOUNT];
  state_e                                 state_d [PINCOUNT];
  logic [PINCOUNT-1:0][MUXWIDTH-1:0]      sel_q, sel_d;
  logic [PINCOUNT-1:0][CntWidth-1:0]      cnt_q, cnt_d;
  logic [PINCOUNT-1:0][SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [PINCOUNT-1:0]                    oe_q, oe_d, out_q, out_d;
  logic [PINCOUNT*RXCOUNT-1:0]            rx_q, rx_d;
  logic [MUXWIDTH-1:0]                    rdata_q, rdata_d;
  logic [MUXWIDTH-1:0]                    sel_in;
  logic [PINCOUNT-1:0]                    wr_hit;
  logic                                   tx_bit;

  // Out-of-range addresses match no pin, so writes drop and readback stays 0.
  for (genvar g = 0; g < PINCOUNT; g++) begin : g_pin
    assign wr_hit[g]   = cfg_we && (32'(cfg_addr) == 32'(g));
    assign pin_busy[g] = (state_q[g] == StDrain);
    assign pin[g]      = oe_q[g] ? out_q[g] : 1'bz;
  end

  assign sel_in = (32'(cfg_sel) > FUNCCOUNT) ? '0 : cfg_sel;

  always_comb begin
    rx_d    = '0;
    oe_d    = '0;
    out_d   = '0;
    rdata_d = '0;
    tx_bit  = 1'b0;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    sync_d  = sync_q;
    for (int p = 0; p < PINCOUNT; p++) begin
      state_d[p] = state_q[p];
      sync_d[p]  = {sync_q[p][SYNC_STAGES-2:0], pin[p]};
      if (32'(cfg_addr) == 32'(p)) rdata_d = sel_q[p];

      unique case (state_q[p])
        StActive: begin
          if (wr_hit[p] && (sel_in != sel_q[p])) begin
            sel_d[p]   = sel_in;
            cnt_d[p]   = CntWidth'(DEADTIME);
            state_d[p] = StDrain;
          end
        end
        StDrain: begin
          // Any write restarts the dead time, even if it repeats the stored value.
          if (wr_hit[p]) begin
            sel_d[p] = sel_in;
            cnt_d[p] = CntWidth'(DEADTIME);
          end else begin
            cnt_d[p] = cnt_q[p] - CntWidth'(1);
            if (cnt_q[p] == CntWidth'(1)) state_d[p] = StActive;
          end
        end
        default: state_d[p] = StActive;
      endcase

      // Only a pin that stays active across this edge may drive or receive.
      if (state_q[p] == StActive && state_d[p] == StActive) begin
        if (32'(sel_q[p]) > RXCOUNT) begin
          tx_bit = func_transmit[32'(p) * TXCOUNT + 32'(sel_q[p]) - RXCOUNT - 1];
`ifdef IO_BANK_ICE40_OPENDRAIN_EN
          oe_d[p]  = ~tx_bit;
          out_d[p] = 1'b0;
`else
          oe_d[p]  = 1'b1;
          out_d[p] = tx_bit;
`endif
        end else if (sel_q[p] != '0) begin
          rx_d[32'(p) * RXCOUNT + 32'(sel_q[p]) - 1] = sync_q[p][SYNC_STAGES-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PINCOUNT; p++) state_q[p] <= StActive;
      sel_q   <= '0;
      cnt_q   <= '0;
      sync_q  <= '0;
      oe_q    <= '0;
      out_q   <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
    end else begin
      for (int p = 0; p < PINCOUNT; p++) state_q[p] <= state_d[p];
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
    end
  end

  assign func_receive = rx_q;
  assign cfg_rdata    = rdata_q;

endmodule

// File: tb/tb_io_bank_ice40.sv
// Directed bench for io_bank_ice40; pins carry pull-ups so a released pin reads 1.
module tb_io_bank_ice40;
  localparam int unsigned PINCOUNT    = 4;
  localparam int unsigned RXCOUNT     = 2;
  localparam int unsigned TXCOUNT     = 2;
  localparam int unsigned DEADTIME    = 4;
  localparam int unsigned SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst;
  wire  [3:0] pin;
  logic [1:0] cfg_addr;
  logic [2:0] cfg_sel;
  logic       cfg_we;
  logic [2:0] cfg_rdata;
  logic [3:0] pin_busy;
  logic [7:0] func_receive;
  logic [7:0] func_transmit;
  logic       drv2_en, drv2_val;

  wire  [2:0] pin3;
  logic [1:0] cfg_addr3;
  logic [2:0] cfg_sel3;
  logic       cfg_we3;
  logic [2:0] cfg_rdata3;
  logic [2:0] pin_busy3;
  logic [5:0] func_receive3;
  logic [5:0] func_transmit3;

  int errs = 0;
  int nchk = 0;

  assign pin[2] = drv2_en ? drv2_val : 1'bz;
  for (genvar i = 0; i < 4; i++) begin : g_pu
    pullup pu (pin[i]);
  end
  for (genvar i = 0; i < 3; i++) begin : g_pu3
    pullup pu3 (pin3[i]);
  end

  always #5 clk = ~clk;

  io_bank_ice40 #(
    .PINCOUNT(PINCOUNT), .RXCOUNT(RXCOUNT), .TXCOUNT(TXCOUNT),
    .DEADTIME(DEADTIME), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .pin(pin), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
    .cfg_we(cfg_we), .cfg_rdata(cfg_rdata), .pin_busy(pin_busy),
    .func_receive(func_receive), .func_transmit(func_transmit)
  );

  io_bank_ice40 #(
    .PINCOUNT(3), .RXCOUNT(RXCOUNT), .TXCOUNT(TXCOUNT),
    .DEADTIME(DEADTIME), .SYNC_STAGES(SYNC_STAGES)
  ) dut3 (
    .clk(clk), .rst(rst), .pin(pin3), .cfg_addr(cfg_addr3), .cfg_sel(cfg_sel3),
    .cfg_we(cfg_we3), .cfg_rdata(cfg_rdata3), .pin_busy(pin_busy3),
    .func_receive(func_receive3), .func_transmit(func_transmit3)
  );

  typedef struct packed {
    logic [1:0] addr;
    logic [2:0] sel;
    logic       busy;
    logic [2:0] rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [2:0] s);
    cfg_addr = a;
    cfg_sel  = s;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic wr3(input logic [1:0] a, input logic [2:0] s);
    cfg_addr3 = a;
    cfg_sel3  = s;
    cfg_we3   = 1'b1;
    tick();
    cfg_we3   = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cfg_addr = '0; cfg_sel = '0; cfg_we = 1'b0; func_transmit = '0;
    cfg_addr3 = '0; cfg_sel3 = '0; cfg_we3 = 1'b0; func_transmit3 = '0;
    drv2_en = 1'b1; drv2_val = 1'b0;

    // {addr, sel, busy right after the write, readback}
    vecs[0] = '{addr: 2'd0, sel: 3'd1, busy: 1'b1, rdata: 3'd1};
    vecs[1] = '{addr: 2'd1, sel: 3'd3, busy: 1'b1, rdata: 3'd3};
    vecs[2] = '{addr: 2'd2, sel: 3'd7, busy: 1'b0, rdata: 3'd0};
    vecs[3] = '{addr: 2'd3, sel: 3'd4, busy: 1'b1, rdata: 3'd4};
    vecs[4] = '{addr: 2'd3, sel: 3'd5, busy: 1'b1, rdata: 3'd0};
    vecs[5] = '{addr: 2'd0, sel: 3'd1, busy: 1'b0, rdata: 3'd1};
    vecs[6] = '{addr: 2'd2, sel: 3'd2, busy: 1'b1, rdata: 3'd2};

    // Reset state
    do_reset();
    chk("rst_pins_hiz", pin, 4'b1011);
    chk("rst_busy", pin_busy, 0);
    chk("rst_rx", func_receive, 0);
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      tick();
      chk("rst_rdata", cfg_rdata, 0);
    end

    // Table: write, dead time, readback
    for (int i = 0; i < 7; i++) begin
      wr(vecs[i].addr, vecs[i].sel);
      chk("tbl_busy", pin_busy[vecs[i].addr], vecs[i].busy);
      repeat (DEADTIME) tick();
      chk("tbl_busy_end", pin_busy, 0);
      tick();
      chk("tbl_rdata", cfg_rdata, vecs[i].rdata);
    end

    // Transmit switch timing on pin1 (data 0 so a driven pin differs from pull-up)
    do_reset();
    wr(2'd1, 3'd3);
    for (int k = 0; k < 4; k++) begin
      chk("tx_busy_drain", pin_busy[1], 1);
      chk("tx_hiz_drain", pin[1], 1);
      tick();
    end
    chk("tx_busy_done", pin_busy[1], 0);
    chk("tx_hiz_n4", pin[1], 1);
    tick();
    chk("tx_drive_n5", pin[1], 0);
    func_transmit[2] = 1'b1;
    chk("tx_latency", pin[1], 0);
    tick();
    chk("tx_follow_1", pin[1], 1);
    func_transmit[2] = 1'b0;
    tick();
    chk("tx_follow_0", pin[1], 0);

    // Receive latency on pin2, rx1
    wr(2'd2, 3'd2);
    repeat (5) tick();
    chk("rx_idle", func_receive, 0);
    drv2_val = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("rx1_latency", func_receive[5], (k == 3) ? 1 : 0);
      chk("rx0_quiet", func_receive[4], 0);
    end
    chk("rx_vector", func_receive, 8'h20);

    // Rewrite during drain on pin0: sel4 then sel1 two cycles later
    wr(2'd0, 3'd4);
    chk("rw_busy_n", pin_busy[0], 1);
    chk("rw_hiz_n", pin[0], 1);
    tick();
    chk("rw_busy_n1", pin_busy[0], 1);
    wr(2'd0, 3'd1);
    for (int k = 0; k < 4; k++) begin
      chk("rw_busy_ext", pin_busy[0], 1);
      chk("rw_hiz_ext", pin[0], 1);
      chk("rw_rx_off", func_receive[1:0], 0);
      tick();
    end
    chk("rw_busy_done", pin_busy[0], 0);
    chk("rw_rx_n6", func_receive[0], 0);
    tick();
    chk("rw_rx_n7", func_receive[1:0], 2'b01);
    chk("rw_rdata", cfg_rdata, 1);

    // Same-value write is a no-op; an oversize select stores 0
    wr(2'd0, 3'd1);
    chk("same_nobusy", pin_busy[0], 0);
    tick();
    chk("same_rx_kept", func_receive[0], 1);
    wr(2'd0, 3'd7);
    chk("clamp_busy", pin_busy[0], 1);
    repeat (DEADTIME) tick();
    chk("clamp_rdata", cfg_rdata, 0);
    chk("clamp_rx_off", func_receive[1:0], 0);

    // Reset in the middle of a drain
    chk("mr_pin1_drv", pin[1], 0);
    wr(2'd0, 3'd2);
    tick();
    chk("mr_in_drain", pin_busy[0], 1);
    rst = 1'b1;
    tick();
    chk("mr_pins_hiz", pin, 4'b1111);
    chk("mr_busy", pin_busy, 0);
    chk("mr_rx", func_receive, 0);
    rst = 1'b0;
    cfg_addr = 2'd0;
    tick();
    chk("mr_rdata", cfg_rdata, 0);
    tick();
    chk("mr_stay_idle", pin_busy, 0);
    chk("mr_pin1_idle", pin[1], 1);

    // Three-pin bank: address 3 is out of range
    wr3(2'd3, 3'd1);
    chk("oor_nobusy", pin_busy3, 0);
    tick();
    chk("oor_rdata", cfg_rdata3, 0);
    wr3(2'd2, 3'd1);
    chk("inr_busy", pin_busy3, 3'b100);
    repeat (DEADTIME) tick();
    chk("inr_rdata", cfg_rdata3, 1);
    cfg_addr3 = 2'd0;
    tick();
    chk("oor_unchanged", cfg_rdata3, 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
